spart_baud_gen: RTL and testbench

//  Programmable baud-tick generator for the SPART. It produces the enable level that the

---
 rtl/spart_baud_gen.sv | 102 ++++++++++
 tb/tb_spart_baud_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_baud_gen.sv
// Programmable baud-tick generator: 16-bit divisor loaded as two byte writes.
// Emits a 1-cycle enable every divisor clocks and a tx_enable every OVERSAMPLE enables.
module spart_baud_gen #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus_in,
    output logic       enable,
    output logic       tx_enable,
    output logic       div_valid
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_PEND = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_div_lo;
    logic [7:0]             r_div_hi;
    logic [DIV_WIDTH-1:0]   r_count;
    logic [DIV_WIDTH-1:0]   w_count_next;
    logic [OS_W-1:0]        r_os_cnt;
    logic [OS_W-1:0]        w_os_cnt_next;

    logic                   w_wr;
    logic                   w_wr_lo;
    logic                   w_wr_hi;
    logic [DIV_WIDTH-1:0]   w_div_new;
    logic [DIV_WIDTH-1:0]   w_div_cur;
    logic                   w_enable;

    assign w_wr      = iocs & ~iorw;
    assign w_wr_lo   = w_wr & (ioaddr == 2'b10);
    assign w_wr_hi   = w_wr & (ioaddr == 2'b11);
    // The divisor being committed pairs the incoming high byte with the stored low byte.
    assign w_div_new = DIV_WIDTH'({databus_in, r_div_lo});
    assign w_div_cur = DIV_WIDTH'({r_div_hi, r_div_lo});
    assign w_enable  = (r_state == RUN) && (r_count == '0);

    assign enable    = w_enable;
    assign tx_enable = w_enable && (r_os_cnt == OS_LAST);
    assign div_valid = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_lo <= '0;
            r_div_hi <= '0;
        end else begin
            if (w_wr_lo) r_div_lo <= databus_in;
            if (w_wr_hi) r_div_hi <= databus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_os_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_os_cnt <= w_os_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_os_cnt_next = r_os_cnt;
        if (w_wr_lo) begin
            w_state_next  = LO_PEND;
            w_os_cnt_next = '0;
        end else if (w_wr_hi) begin
            w_os_cnt_next = '0;
            if (w_div_new == '0) begin
                w_state_next = IDLE;
            end else begin
                w_state_next = RUN;
                w_count_next = w_div_new - DIV_WIDTH'(1);
            end
        end else if (r_state == RUN) begin
            if (w_enable) begin
                w_count_next  = w_div_cur - DIV_WIDTH'(1);
                w_os_cnt_next = (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
            end else begin
                w_count_next = r_count - DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_spart_baud_gen.sv
// Bench for spart_baud_gen: randomized register traffic checked every cycle against
// an arithmetic model (ticks at multiples of D since the high write), plus directed checks.
module tb_spart_baud_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] databus_in = 8'h00;
    logic       enable;
    logic       tx_enable;
    logic       div_valid;

    int checks = 0;
    int errors = 0;

    // Model: running flag, divisor, cycles elapsed since the committing high write.
    bit         chk_en = 1'b0;
    bit         m_run = 1'b0;
    int         m_d = 0;
    int         m_el = 0;
    logic [7:0] m_lo = 8'h00;
    logic [7:0] m_hi = 8'h00;

    spart_baud_gen #(.DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus_in(databus_in), .enable(enable), .tx_enable(tx_enable),
        .div_valid(div_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                chk_en = 1'b1;
                m_run = 1'b0; m_lo = 8'h00; m_hi = 8'h00; m_el = 0;
            end else if (iocs && !iorw && ioaddr == 2'b10) begin
                m_lo = databus_in;
                m_run = 1'b0;
            end else if (iocs && !iorw && ioaddr == 2'b11) begin
                m_hi = databus_in;
                m_d = int'({m_hi, m_lo});
                m_run = (m_d != 0);
                m_el = 1;
            end else if (m_run) begin
                m_el++;
            end
        end
    end

    initial begin
        bit e_en;
        bit e_tx;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_en = m_run && (m_el % m_d == 0);
                e_tx = e_en && ((m_el / m_d) % 16 == 0);
                chk("enable", int'(enable), int'(e_en));
                chk("tx_enable", int'(tx_enable), int'(e_tx));
                chk("div_valid", int'(div_valid), int'(m_run));
            end
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) align();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus_in = d;
        align();
        iocs = 1'b0;
        $display("WR addr=%0d data=0x%02h", a, d);
    endtask

    // Register traffic that must not disturb the generator.
    task automatic junk();
        int k;
        k = $urandom_range(0, 2);
        databus_in = 8'($urandom);
        case (k)
            0: begin iocs = 1'b1; iorw = 1'b1; ioaddr = 2'($urandom_range(2, 3)); end
            1: begin iocs = 1'b0; iorw = 1'b0; ioaddr = 2'($urandom_range(2, 3)); end
            default: begin iocs = 1'b1; iorw = 1'b0; ioaddr = 2'($urandom_range(0, 1)); end
        endcase
        align();
        $display("JUNK kind=%0d addr=%0d data=0x%02h", k, ioaddr, databus_in);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // Counts negedges up to and including the next one where the chosen output is high.
    task automatic wait_sig(input bit tx, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx ? tx_enable : enable) && n < max);
        if (n >= max && !(tx ? tx_enable : enable))
            chk("wait_timeout", n, -1);
    endtask

    task automatic count_en(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (enable) c++;
        end
    endtask

    initial begin
        int n;
        int c;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_enable", int'(enable), 0);
        chk("reset_valid", int'(div_valid), 0);
        align();

        // D=4: first enable 4 cycles after the high write, then every 4.
        wr(2'b10, 8'h04);
        wr(2'b11, 8'h00);
        @(negedge clk);
        chk("t1_valid_next", int'(div_valid), 1);
        wait_sig(1'b0, 50, n);
        chk("t1_first_en", n, 3);
        wait_sig(1'b0, 50, n);
        chk("t1_period", n, 4);
        align();

        // D=3: tx_enable every 48 clocks.
        wr(2'b10, 8'h03);
        wr(2'b11, 8'h00);
        wait_sig(1'b1, 200, n);
        wait_sig(1'b1, 200, n);
        chk("t2_tx_period", n, 48);
        align();
        idle(100);

        // D=5, abort with a low write, restart with a high write.
        wr(2'b10, 8'h05);
        wr(2'b11, 8'h00);
        idle(12);
        wr(2'b10, 8'h05);
        @(negedge clk);
        chk("t3_abort_valid", int'(div_valid), 0);
        chk("t3_abort_en", int'(enable), 0);
        align();
        idle(6);
        wr(2'b11, 8'h00);
        wait_sig(1'b0, 50, n);
        chk("t3_restart_first", n, 5);
        wait_sig(1'b1, 200, n);
        chk("t3_os_restart", n, 75);
        align();

        // D=0 stays idle; D=1 ticks every cycle.
        wr(2'b10, 8'h00);
        wr(2'b11, 8'h00);
        count_en(100, c);
        chk("t4_d0_none", c, 0);
        align();
        wr(2'b10, 8'h01);
        wr(2'b11, 8'h00);
        count_en(20, c);
        chk("t4_d1_every", c, 20);
        align();

        // Ignored traffic while running at D=7.
        wr(2'b10, 8'h07);
        wr(2'b11, 8'h00);
        repeat (60) junk();
        wait_sig(1'b0, 50, n);
        wait_sig(1'b0, 50, n);
        chk("t5_period", n, 7);
        align();

        // Reset mid-count at D=0x0102.
        wr(2'b10, 8'h02);
        wr(2'b11, 8'h01);
        idle(100);
        rst = 1'b1;
        align();
        rst = 1'b0;
        $display("RST pulse");
        @(negedge clk);
        chk("t6_en", int'(enable), 0);
        chk("t6_tx", int'(tx_enable), 0);
        chk("t6_valid", int'(div_valid), 0);
        count_en(300, c);
        chk("t6_no_en", c, 0);
        align();

        // Randomized traffic, checked cycle by cycle against the model.
        repeat (400) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10) idle($urandom_range(1, 15));
            else if (r < 13) wr(2'b10, 8'($urandom_range(0, 9)));
            else if (r < 16) wr(2'b11, ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00);
            else if (r < 19) junk();
            else begin
                rst = 1'b1;
                align();
                rst = 1'b0;
                $display("RST pulse");
            end
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
